// File: rtl/output_scoreboard_pkg.sv
// Shared types and helpers for the output scoreboard: run-state encoding,
// a width-aware saturating increment and the masked mismatch function.
package output_scoreboard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Operates on a 64-bit container; w selects the live width so callers of
   // any width up to 64 share one implementation.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
      logic [63:0] max_v;
      if (w >= 64) max_v = {64{1'b1}};
      else         max_v = (64'd1 << w) - 64'd1;
      return (v >= max_v) ? v : v + 64'd1;
   endfunction

   function automatic logic [63:0] mismatch_bits(input logic [63:0] e,
                                                 input logic [63:0] a,
                                                 input logic [63:0] c);
      return (e ^ a) & c;
   endfunction

endpackage

// File: rtl/output_scoreboard_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter
   import output_scoreboard_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (inc) cnt_d = WIDTH'(sat_inc(64'(cnt_q), WIDTH));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/output_scoreboard.sv
// Synthesizable output checker: counts samples and masked mismatches over a
// run and reports a registered pass/fail verdict when the run ends.
module output_scoreboard
   import output_scoreboard_pkg::*;
#(
   parameter int          WIDTH       = 1,
   parameter int          CNT_W       = 32,
   parameter int unsigned MAX_SAMPLES = 100
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic [WIDTH-1:0] exp,
   input  logic [WIDTH-1:0] act,
   input  logic [WIDTH-1:0] care,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             first_err_vld,
   output logic [WIDTH-1:0] err_mask,
   output state_e           dbg_state
);

   state_e           state_q, state_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
   logic             first_err_vld_q, first_err_vld_d;
   logic [WIDTH-1:0] err_mask_q, err_mask_d;

   logic             run_clr;
   logic             sample_fire;
   logic             err_fire;
   logic             auto_end;
   logic [WIDTH-1:0] mis_bits;
   logic [CNT_W-1:0] sample_next;

   assign run_clr     = start && (state_q != ST_RUN);
   assign sample_fire = (state_q == ST_RUN) && en;
   assign mis_bits    = WIDTH'(mismatch_bits(64'(exp), 64'(act), 64'(care)));
   assign err_fire    = sample_fire && (|mis_bits);
   assign sample_next = CNT_W'(sat_inc(64'(sample_cnt), CNT_W));
   // The sample that brings the count to MAX_SAMPLES is itself part of the run.
   assign auto_end    = (MAX_SAMPLES != 0) && sample_fire &&
                        (64'(sample_next) == 64'(MAX_SAMPLES));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
         ST_RUN:           if (stop || auto_end) state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      done_d          = (state_q == ST_RUN) && (state_d == ST_DONE);
      first_err_idx_d = first_err_idx_q;
      first_err_vld_d = first_err_vld_q;
      err_mask_d      = err_mask_q;
      if (run_clr) begin
         first_err_idx_d = '0;
         first_err_vld_d = 1'b0;
         err_mask_d      = '0;
      end else if (err_fire) begin
         err_mask_d = err_mask_q | mis_bits;
         if (!first_err_vld_q) begin
            first_err_idx_d = sample_cnt;
            first_err_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q         <= ST_IDLE;
         done_q          <= 1'b0;
         first_err_idx_q <= '0;
         first_err_vld_q <= 1'b0;
         err_mask_q      <= '0;
      end else begin
         state_q         <= state_d;
         done_q          <= done_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_vld_q <= first_err_vld_d;
         err_mask_q      <= err_mask_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (run_clr),
      .inc    (sample_fire),
      .cnt    (sample_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (run_clr),
      .inc    (err_fire),
      .cnt    (err_cnt)
   );

   assign busy          = (state_q == ST_RUN);
   assign done          = done_q;
   assign pass          = (state_q == ST_DONE) && (err_cnt == '0);
   assign first_err_idx = first_err_idx_q;
   assign first_err_vld = first_err_vld_q;
   assign err_mask      = err_mask_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_output_scoreboard.sv
// Directed plus randomized bench for output_scoreboard; two instances cover a
// 4-bit/100-sample configuration and a 4-bit-counter free-running one.
module tb_output_scoreboard;
   import output_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   // Instance a: WIDTH=4, CNT_W=32, MAX_SAMPLES=100
   logic        start_a = 0, stop_a = 0, en_a = 0;
   logic [3:0]  exp_a = 0, act_a = 0, care_a = 0;
   logic        busy_a, done_a, pass_a, first_err_vld_a;
   logic [31:0] sample_cnt_a, err_cnt_a, first_err_idx_a;
   logic [3:0]  err_mask_a;
   state_e      dbg_state_a;

   // Instance b: WIDTH=1, CNT_W=4, MAX_SAMPLES=0
   logic        start_b = 0, stop_b = 0, en_b = 0;
   logic [0:0]  exp_b = 0, act_b = 0, care_b = 0;
   logic        busy_b, done_b, pass_b, first_err_vld_b;
   logic [3:0]  sample_cnt_b, err_cnt_b, first_err_idx_b;
   logic [0:0]  err_mask_b;
   state_e      dbg_state_b;

   output_scoreboard #(.WIDTH(4), .CNT_W(32), .MAX_SAMPLES(100)) dut_a (
      .clk(clk), .resetn(resetn), .start(start_a), .stop(stop_a), .en(en_a),
      .exp(exp_a), .act(act_a), .care(care_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .sample_cnt(sample_cnt_a), .err_cnt(err_cnt_a),
      .first_err_idx(first_err_idx_a), .first_err_vld(first_err_vld_a),
      .err_mask(err_mask_a), .dbg_state(dbg_state_a)
   );

   output_scoreboard #(.WIDTH(1), .CNT_W(4), .MAX_SAMPLES(0)) dut_b (
      .clk(clk), .resetn(resetn), .start(start_b), .stop(stop_b), .en(en_b),
      .exp(exp_b), .act(act_b), .care(care_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .sample_cnt(sample_cnt_b), .err_cnt(err_cnt_b),
      .first_err_idx(first_err_idx_b), .first_err_vld(first_err_vld_b),
      .err_mask(err_mask_b), .dbg_state(dbg_state_b)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: per-instance run statistics, index 0 = a, 1 = b
   longint unsigned m_cnt[2], m_err[2], m_idx[2], m_mask[2];
   bit              m_vld[2], m_run[2], m_fin[2], m_pulse[2];
   longint unsigned m_cmax[2] = '{64'hFFFF_FFFF, 64'd15};
   longint unsigned m_max[2]  = '{64'd100, 64'd0};

   task automatic check(input string tag, input longint unsigned obs,
                        input longint unsigned expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_err[i] = 0; m_idx[i] = 0; m_mask[i] = 0;
         m_vld[i] = 0; m_run[i] = 0; m_fin[i] = 0; m_pulse[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit st, input bit sp, input bit e,
                             input longint unsigned ex, input longint unsigned ac,
                             input longint unsigned ca);
      longint unsigned diff;
      diff = (ex ^ ac) & ca;
      m_pulse[i] = 0;
      if (m_run[i]) begin
         if (e) begin
            if (diff != 0) begin
               if (!m_vld[i]) begin
                  m_idx[i] = m_cnt[i];
                  m_vld[i] = 1;
               end
               if (m_err[i] < m_cmax[i]) m_err[i]++;
               m_mask[i] |= diff;
            end
            if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
         end
         if (sp || (m_max[i] != 0 && e && m_cnt[i] == m_max[i])) begin
            m_run[i] = 0;
            m_fin[i] = 1;
            m_pulse[i] = 1;
         end
      end else if (st) begin
         m_cnt[i] = 0; m_err[i] = 0; m_idx[i] = 0; m_mask[i] = 0; m_vld[i] = 0;
         m_run[i] = 1;
         m_fin[i] = 0;
      end
   endtask

   task automatic check_a();
      check("a_busy", 64'(busy_a), 64'(m_run[0]));
      check("a_done", 64'(done_a), 64'(m_pulse[0]));
      check("a_pass", 64'(pass_a), 64'(m_fin[0] && m_err[0] == 0));
      check("a_sample_cnt", 64'(sample_cnt_a), m_cnt[0]);
      check("a_err_cnt", 64'(err_cnt_a), m_err[0]);
      check("a_first_err_vld", 64'(first_err_vld_a), 64'(m_vld[0]));
      check("a_first_err_idx", 64'(first_err_idx_a), m_idx[0]);
      check("a_err_mask", 64'(err_mask_a), m_mask[0]);
   endtask

   task automatic check_b();
      check("b_busy", 64'(busy_b), 64'(m_run[1]));
      check("b_done", 64'(done_b), 64'(m_pulse[1]));
      check("b_pass", 64'(pass_b), 64'(m_fin[1] && m_err[1] == 0));
      check("b_sample_cnt", 64'(sample_cnt_b), m_cnt[1]);
      check("b_err_cnt", 64'(err_cnt_b), m_err[1]);
      check("b_first_err_vld", 64'(first_err_vld_b), 64'(m_vld[1]));
      check("b_first_err_idx", 64'(first_err_idx_b), m_idx[1]);
      check("b_err_mask", 64'(err_mask_b), m_mask[1]);
   endtask

   task automatic cycle_a(input bit st, input bit sp, input bit e,
                          input logic [3:0] ex, input logic [3:0] ac,
                          input logic [3:0] ca);
      @(negedge clk);
      start_a = st; stop_a = sp; en_a = e; exp_a = ex; act_a = ac; care_a = ca;
      @(posedge clk);
      model_step(0, st, sp, e, 64'(ex), 64'(ac), 64'(ca));
      #1;
      start_a = 0; stop_a = 0; en_a = 0;
      exp_a = 4'($urandom); act_a = 4'($urandom); care_a = 4'($urandom);
      check_a();
   endtask

   task automatic cycle_b(input bit st, input bit sp, input bit e,
                          input logic ex, input logic ac, input logic ca);
      @(negedge clk);
      start_b = st; stop_b = sp; en_b = e;
      exp_b = ex; act_b = ac; care_b = ca;
      @(posedge clk);
      model_step(1, st, sp, e, 64'(ex), 64'(ac), 64'(ca));
      #1;
      start_b = 0; stop_b = 0; en_b = 0;
      check_b();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_a();
      check_b();

      // en and stop ignored in IDLE
      cycle_a(0, 1, 1, 4'h0, 4'hF, 4'hF);

      // Clean run to auto-end
      cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 100; i++) cycle_a(0, 0, 1, 4'h0, 4'h0, 4'hF);
      check("c1_cnt", 64'(sample_cnt_a), 64'd100);
      check("c1_done", 64'(done_a), 64'd1);
      check("c1_pass", 64'(pass_a), 64'd1);
      // Results held and samples ignored in DONE
      cycle_a(0, 1, 1, 4'h0, 4'hF, 4'hF);
      check("c1_hold_done_low", 64'(done_a), 64'd0);

      // Errors on samples 7 and 40
      cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 100; i++)
         cycle_a(0, 0, 1, 4'h0, (i == 7 || i == 40) ? 4'h1 : 4'h0, 4'h1);
      check("c2_err_cnt", 64'(err_cnt_a), 64'd2);
      check("c2_first_idx", 64'(first_err_idx_a), 64'd7);
      check("c2_mask", 64'(err_mask_a), 64'd1);
      check("c2_pass", 64'(pass_a), 64'd0);

      // Restart from a failing DONE clears the statistics
      cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
      check("c6_restart_err", 64'(err_cnt_a), 64'd0);
      check("c6_restart_vld", 64'(first_err_vld_a), 64'd0);
      check("c6_restart_mask", 64'(err_mask_a), 64'd0);

      // Care mask
      cycle_a(0, 0, 1, 4'hA, 4'hB, 4'hE);
      check("c3_masked", 64'(err_cnt_a), 64'd0);
      cycle_a(0, 0, 1, 4'hA, 4'hB, 4'hF);
      cycle_a(0, 1, 0, 4'h0, 4'h0, 4'h0);
      check("c3_err_cnt", 64'(err_cnt_a), 64'd1);
      check("c3_mask", 64'(err_mask_a), 64'd1);

      // Early stop together with the 10th sample
      cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 10; i++) cycle_a(0, i == 9, 1, 4'h5, 4'h5, 4'hF);
      check("c4_cnt10", 64'(sample_cnt_a), 64'd10);
      check("c4_done10", 64'(done_a), 64'd1);
      // Early stop without a sample after 9
      cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 9; i++) cycle_a(0, 0, 1, 4'h5, 4'h5, 4'hF);
      cycle_a(0, 1, 0, 4'h0, 4'h0, 4'h0);
      check("c4_cnt9", 64'(sample_cnt_a), 64'd9);

      // Randomized runs; start pulses inside RUN must be ignored
      for (int r = 0; r < 6; r++) begin
         cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
         for (int k = 0; k < 200 && m_run[0]; k++) begin
            logic [3:0] ex, ac;
            ex = 4'($urandom);
            ac = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ex;
            cycle_a($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) != 0, ex, ac, 4'($urandom));
         end
      end

      // Reset mid-run after sample 50
      cycle_a(1, 0, 0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 50; i++) cycle_a(0, 0, 1, 4'h3, 4'h1, 4'hF);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      model_reset();
      check_a();
      check("c6_rst_busy", 64'(busy_a), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) cycle_a(0, 0, 1, 4'h3, 4'h1, 4'hF);

      // Saturation with 4-bit counters and no auto-end
      cycle_b(1, 0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle_b(0, 0, 1, 1'b0, 1'b1, 1'b1);
      cycle_b(0, 1, 0, 1'b0, 1'b0, 1'b0);
      check("c5_sample_sat", 64'(sample_cnt_b), 64'd15);
      check("c5_err_sat", 64'(err_cnt_b), 64'd15);
      check("c5_first_idx", 64'(first_err_idx_b), 64'd0);
      cycle_b(0, 0, 0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/output_scoreboard.md
# output_scoreboard

- Synthesizable checker that sits directly downstream of a device-under-test output.
- Compares each sampled DUT value against an expected value under a care mask.
- Counts samples and mismatches, records the sample index of the first mismatch and a sticky per-bit mismatch mask.
- Reports a single pass/fail verdict when the run ends: it is the hardware form of the mismatch bookkeeping the team's benches perform on every output.

## Interface
Parameters:
- WIDTH, 1 — width of compared vectors
- CNT_W, 32 — width of all counters
- MAX_SAMPLES, 100 — run ends automatically after this many counted samples; 0 disables auto-end

Ports:
- clk  in  1  sole clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin a run; clears all statistics
- stop  in  1  end a run early
- en  in  1  sample strobe; exp/act/care valid this cycle
- exp  in  WIDTH  expected (reference) value
- act  in  WIDTH  actual (DUT) value
- care  in  WIDTH  1 = bit is checked, 0 = don't-care
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on entry to DONE
- pass  out  1  valid in DONE: err_cnt == 0
- sample_cnt  out  CNT_W  samples counted this run
- err_cnt  out  CNT_W  mismatching samples this run
- first_err_idx  out  CNT_W  sample_cnt value at first mismatch (0-based)
- first_err_vld  out  1  first_err_idx holds a valid index
- err_mask  out  WIDTH  sticky OR of mismatching bits

## Operation
- Mismatch for a sample: ((exp ^ act) & care) != 0.
- States:
  - IDLE: statistics held, en ignored; start -> RUN.
  - RUN: counts samples; stop, or sample_cnt reaching MAX_SAMPLES -> DONE.
  - DONE: results held, en ignored; start -> RUN.
- On start, from IDLE or DONE, clear sample_cnt, err_cnt, first_err_idx, first_err_vld and err_mask in the same edge that enters RUN.
- start is ignored in RUN.
- In RUN with en=1, on each edge:
  - sample_cnt += 1.
  - On mismatch, err_cnt += 1 and err_mask |= (exp ^ act) & care.
  - If the sample mismatches and first_err_vld=0, first_err_idx <= pre-increment sample_cnt and first_err_vld <= 1.
- Counters saturate at all-ones and never wrap; first_err_idx is never overwritten within a run.
- Auto-end: when MAX_SAMPLES != 0 and the sample being counted makes sample_cnt == MAX_SAMPLES, enter DONE on that same edge; that sample is included.
- stop and en in the same RUN cycle: the sample is counted, then DONE.
- stop in IDLE or DONE: ignored.
- pass = (state == DONE) && (err_cnt == 0); it is 0 outside DONE.

## Timing
- Reset values: state IDLE; busy 0, done 0, pass 0, all counters 0, first_err_vld 0, err_mask 0.
- All outputs are registered, or decoded only from registered state.
- Latency: a sample at edge N is visible on the counters after edge N.
- done is high for exactly the cycle following the RUN->DONE edge.
- busy rises the cycle after start is accepted and falls in the same cycle done rises.
- resetn asserted mid-run: immediate return to the reset values. No done pulse, and results are lost.
- Inputs exp/act/care are sampled only when en=1 in RUN; their values are don't-care otherwise.

## Structure
- A shared package holds:
  - state enum (IDLE, RUN, DONE)
  - a saturating-increment function parameterised on width
  - a mismatch-function helper
- One sub-module is natural: sat_counter (WIDTH param; inputs clr, inc; output cnt; saturates at all-ones). Instantiate it for sample_cnt and err_cnt.
- FSM, first-error capture and err_mask stay in output_scoreboard.

## Test plan
All cases use WIDTH=1 and MAX_SAMPLES=100 unless stated.
1. Clean run: start, then 100 en cycles with exp=act=0 and care=1 -> done pulses after the 100th sample; sample_cnt=100, err_cnt=0, pass=1, first_err_vld=0.
2. Errors: act=1 on samples 7 and 40, others match -> err_cnt=2, first_err_idx=7, err_mask=1, pass=0 in DONE.
3. Care mask: WIDTH=4, exp=4'hA, act=4'hB, care=4'hE -> no error counted. Then care=4'hF -> err_cnt=1, err_mask=4'h1.
4. Early stop: stop asserted together with en on sample 10 -> sample_cnt=10, done the following cycle. Repeat with en and stop low before the 10th sample: sample_cnt=9.
5. Saturation: CNT_W=4, MAX_SAMPLES=0, 20 mismatching samples, then stop -> sample_cnt=15, err_cnt=15.
6. Reset and restart: resetn low for one cycle after sample 50 -> all outputs at reset values immediately, no done pulse. Then start from DONE of a prior failing run -> err_cnt, first_err_vld and err_mask cleared at RUN entry.
